// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_ctrl_pkg;

    typedef logic [31:0] addr_bus_t;

    localparam addr_bus_t ZERO_32          = '0;
    localparam addr_bus_t RESET_PC_DEFAULT = 32'hBFC0_0000;

    typedef enum logic [2:0] {
        FE_RST,
        FE_REQ,
        FE_WAIT,
        FE_OUT,
        FE_DISCARD
    } fe_state_t;

endpackage

// File: rtl/fetch_ctrl_if.sv
// SRAM-like instruction read bus between the fetch controller and the instruction memory.
interface fetch_ctrl_if;
    import fetch_ctrl_pkg::*;

    logic      inst_req;
    addr_bus_t inst_addr;
    logic      inst_addr_ok;
    logic      inst_data_ok;
    addr_bus_t inst_rdata;

    modport master (
        output inst_req,
        output inst_addr,
        input  inst_addr_ok,
        input  inst_data_ok,
        input  inst_rdata
    );

    modport slave (
        input  inst_req,
        input  inst_addr,
        output inst_addr_ok,
        output inst_data_ok,
        output inst_rdata
    );

endinterface

// File: rtl/fetch_ctrl_fe_redirect.sv
// Pending-redirect register: holds a branch or flush target until the fetch FSM consumes it.
module fe_redirect
    import fetch_ctrl_pkg::*;
(
    input  logic      clk,
    input  logic      resetn,
    input  logic      flush,
    input  addr_bus_t flush_pc,
    input  logic      br_taken,
    input  addr_bus_t br_target,
    input  logic      consume,
    output logic      redir_valid,
    output addr_bus_t redir_target
);

    logic      pend_valid;
    logic      pend_flush;
    addr_bus_t pend_target;

    // Same-cycle requests bypass the register; a stored flush target is never replaced by a branch.
    always_comb begin
        redir_valid  = pend_valid;
        redir_target = pend_target;
        if (flush) begin
            redir_valid  = 1'b1;
            redir_target = flush_pc;
        end else if (br_taken && !pend_flush) begin
            redir_valid  = 1'b1;
            redir_target = br_target;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pend_valid  <= 1'b0;
            pend_flush  <= 1'b0;
            pend_target <= ZERO_32;
        end else if (consume) begin
            pend_valid  <= 1'b0;
            pend_flush  <= 1'b0;
        end else if (flush) begin
            pend_valid  <= 1'b1;
            pend_flush  <= 1'b1;
            pend_target <= flush_pc;
        end else if (br_taken && !pend_flush) begin
            pend_valid  <= 1'b1;
            pend_target <= br_target;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding SRAM-like read, output register with stall,
// delayed-branch and flush redirection.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter addr_bus_t RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                flush,
    input  addr_bus_t           flush_pc,
    input  logic                br_taken,
    input  addr_bus_t           br_target,
    input  logic                stall_fe,
    fetch_ctrl_if.master        inst_bus,
    output logic                fe_valid,
    output addr_bus_t           fe_pc,
    output addr_bus_t           fe_inst
);

    fe_state_t state, state_n;
    addr_bus_t pc, pc_n;
    addr_bus_t out_pc, out_inst;
    logic      capture;
    logic      consume;
    logic      redir_valid;
    addr_bus_t redir_target;

    fe_redirect u_redirect (
        .clk          (clk),
        .resetn       (resetn),
        .flush        (flush),
        .flush_pc     (flush_pc),
        .br_taken     (br_taken),
        .br_target    (br_target),
        .consume      (consume),
        .redir_valid  (redir_valid),
        .redir_target (redir_target)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= FE_RST;
            pc       <= ZERO_32;
            out_pc   <= ZERO_32;
            out_inst <= ZERO_32;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            if (capture) begin
                out_pc   <= pc;
                out_inst <= inst_bus.inst_rdata;
            end
        end
    end

    // Every redirect goes through redir_target so a stored flush survives into DISCARD.
    always_comb begin
        state_n = state;
        pc_n    = pc;
        capture = 1'b0;
        consume = 1'b0;
        case (state)
            FE_RST: begin
                state_n = FE_REQ;
                pc_n    = RESET_PC;
            end
            FE_REQ: begin
                if (flush) begin
                    if (inst_bus.inst_addr_ok) begin
                        state_n = FE_DISCARD;
                    end else begin
                        pc_n    = redir_target;
                        consume = 1'b1;
                    end
                end else if (inst_bus.inst_addr_ok) begin
                    state_n = FE_WAIT;
                end
            end
            FE_WAIT: begin
                if (flush) begin
                    if (inst_bus.inst_data_ok) begin
                        state_n = FE_REQ;
                        pc_n    = redir_target;
                        consume = 1'b1;
                    end else begin
                        state_n = FE_DISCARD;
                    end
                end else if (inst_bus.inst_data_ok) begin
                    state_n = FE_OUT;
                    capture = 1'b1;
                end
            end
            FE_OUT: begin
                if (flush) begin
                    state_n = FE_REQ;
                    pc_n    = redir_target;
                    consume = 1'b1;
                end else if (!stall_fe) begin
                    state_n = FE_REQ;
                    if (redir_valid) begin
                        pc_n    = redir_target;
                        consume = 1'b1;
                    end else begin
                        pc_n = pc + 32'd4;
                    end
                end
            end
            FE_DISCARD: begin
                if (inst_bus.inst_data_ok) begin
                    state_n = FE_REQ;
                    pc_n    = redir_target;
                    consume = 1'b1;
                end
            end
            default: state_n = FE_RST;
        endcase
    end

    assign inst_bus.inst_req  = (state == FE_REQ);
    assign inst_bus.inst_addr = pc;
    assign fe_valid           = (state == FE_OUT);
    assign fe_pc              = fe_valid ? out_pc   : ZERO_32;
    assign fe_inst            = fe_valid ? out_inst : ZERO_32;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a latency-programmable instruction memory model.
module tb_fetch_ctrl;
    import fetch_ctrl_pkg::*;

    localparam logic [31:0] KEY = 32'h5A5A_F00F;

    logic        clk = 1'b0;
    logic        resetn;
    logic        flush;
    logic [31:0] flush_pc;
    logic        br_taken;
    logic [31:0] br_target;
    logic        stall_fe;
    logic        fe_valid;
    logic [31:0] fe_pc;
    logic [31:0] fe_inst;

    fetch_ctrl_if bus ();

    fetch_ctrl #(.RESET_PC(32'hBFC0_0000)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .flush     (flush),
        .flush_pc  (flush_pc),
        .br_taken  (br_taken),
        .br_target (br_target),
        .stall_fe  (stall_fe),
        .inst_bus  (bus),
        .fe_valid  (fe_valid),
        .fe_pc     (fe_pc),
        .fe_inst   (fe_inst)
    );

    always #5 clk = ~clk;

    // Memory model: data returns lat cycles after the accepting edge, rdata = addr ^ KEY.
    logic        addr_ok_en;
    int unsigned lat;
    logic        slv_busy;
    int unsigned slv_cnt;
    logic [31:0] slv_addr;

    assign bus.inst_addr_ok = bus.inst_req & addr_ok_en;
    assign bus.inst_data_ok = slv_busy && (slv_cnt == 0);
    assign bus.inst_rdata   = bus.inst_data_ok ? (slv_addr ^ KEY) : '0;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            slv_busy <= 1'b0;
            slv_cnt  <= 0;
            slv_addr <= '0;
        end else if (bus.inst_req && bus.inst_addr_ok) begin
            slv_busy <= 1'b1;
            slv_addr <= bus.inst_addr;
            slv_cnt  <= lat - 1;
        end else if (bus.inst_data_ok) begin
            slv_busy <= 1'b0;
        end else if (slv_busy) begin
            slv_cnt <= slv_cnt - 1;
        end
    end

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic [31:0] req_log[$];
    logic [31:0] xfer_pc[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Logs what the DUT will see at the coming edge, then advances to the next sample point.
    task automatic step();
        #1;
        if (bus.inst_req && bus.inst_addr_ok) req_log.push_back(bus.inst_addr);
        if (fe_valid && !stall_fe) xfer_pc.push_back(fe_pc);
        @(negedge clk);
    endtask

    initial begin
        int unsigned hits;
        resetn = 1'b0; flush = 1'b0; br_taken = 1'b0; stall_fe = 1'b0;
        flush_pc = '0; br_target = '0; addr_ok_en = 1'b1; lat = 1;
        step(); step();
        check("rst_req",   32'(bus.inst_req), 32'd0);
        check("rst_addr",  bus.inst_addr, 32'd0);
        check("rst_valid", 32'(fe_valid), 32'd0);
        check("rst_pc",    fe_pc, 32'd0);
        check("rst_inst",  fe_inst, 32'd0);
        resetn = 1'b1;

        for (int i = 0; i < 9; i++) begin
            step();
            check("seq_req",   32'(bus.inst_req), 32'(i % 3 == 0));
            check("seq_valid", 32'(fe_valid),     32'(i % 3 == 2));
            if (i % 3 == 0) check("seq_addr", bus.inst_addr, 32'hBFC0_0000 + 32'(4 * (i / 3)));
            if (i % 3 == 2) begin
                check("seq_pc",   fe_pc,   32'hBFC0_0000 + 32'(4 * (i / 3)));
                check("seq_inst", fe_inst, (32'hBFC0_0000 + 32'(4 * (i / 3))) ^ KEY);
            end
        end
        check("seq_nreq", 32'(req_log.size()), 32'd3);
        if (req_log.size() == 3) check("seq_req2", req_log[2], 32'hBFC0_0008);
        req_log.delete(); xfer_pc.delete();

        step();
        check("stl_addr", bus.inst_addr, 32'hBFC0_000C);
        step();
        stall_fe = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check("stl_valid", 32'(fe_valid), 32'd1);
            check("stl_pc",    fe_pc,   32'hBFC0_000C);
            check("stl_inst",  fe_inst, 32'hBFC0_000C ^ KEY);
            check("stl_noreq", 32'(bus.inst_req), 32'd0);
        end
        stall_fe = 1'b0;
        step();
        check("stl_nxfer", 32'(xfer_pc.size()), 32'd2);
        if (xfer_pc.size() == 2) check("stl_xfer", xfer_pc[1], 32'hBFC0_000C);
        check("stl_next", bus.inst_addr, 32'hBFC0_0010);

        step();
        br_taken = 1'b1; br_target = 32'h8000_1000;
        step();
        br_taken = 1'b0;
        check("br_slot", fe_pc, 32'hBFC0_0010);
        step();
        check("br_req", bus.inst_addr, 32'h8000_1000);
        step(); step();
        check("br_out", fe_pc, 32'h8000_1000);
        lat = 4;
        step();
        check("br_clear", bus.inst_addr, 32'h8000_1004);
        xfer_pc.delete();

        step();
        check("fw_wait", 32'(bus.inst_req), 32'd0);
        flush = 1'b1; flush_pc = 32'hBFC0_0380;
        step();
        flush = 1'b0;
        check("fw_disc_v", 32'(fe_valid), 32'd0);
        check("fw_disc_r", 32'(bus.inst_req), 32'd0);
        step();
        check("fw_disc_v", 32'(fe_valid), 32'd0);
        step();
        check("fw_dataok", 32'(bus.inst_data_ok), 32'd1);
        lat = 1;
        step();
        check("fw_req", bus.inst_addr, 32'hBFC0_0380);
        check("fw_valid", 32'(fe_valid), 32'd0);
        check("fw_noxfer", 32'(xfer_pc.size()), 32'd0);

        step(); step();
        check("fb_out", fe_pc, 32'hBFC0_0380);
        flush = 1'b1; flush_pc = 32'hBFC0_0400;
        br_taken = 1'b1; br_target = 32'h8000_2000;
        step();
        flush = 1'b0; br_taken = 1'b0;
        check("fb_valid", 32'(fe_valid), 32'd0);
        check("fb_req",   bus.inst_addr, 32'hBFC0_0400);
        step(); step();
        check("fb_out2", fe_pc, 32'hBFC0_0400);
        step();
        check("fb_next", bus.inst_addr, 32'hBFC0_0404);
        hits = 0;
        foreach (req_log[j]) if (req_log[j] == 32'h8000_2000) hits++;
        check("fb_no_br", 32'(hits), 32'd0);

        addr_ok_en = 1'b0; flush = 1'b1; flush_pc = 32'hBFC0_0500;
        step();
        flush = 1'b0; addr_ok_en = 1'b1;
        check("fr_req",  32'(bus.inst_req), 32'd1);
        check("fr_addr", bus.inst_addr, 32'hBFC0_0500);
        step(); step();
        check("fr_out",  fe_pc,   32'hBFC0_0500);
        check("fr_inst", fe_inst, 32'hBFC0_0500 ^ KEY);

        step();
        check("fd_req", bus.inst_addr, 32'hBFC0_0504);
        step();
        check("fd_dataok", 32'(bus.inst_data_ok), 32'd1);
        flush = 1'b1; flush_pc = 32'hBFC0_0600;
        step();
        flush = 1'b0;
        check("fd_valid", 32'(fe_valid), 32'd0);
        check("fd_addr",  bus.inst_addr, 32'hBFC0_0600);

        step();
        resetn = 1'b0;
        #1;
        check("ar_req",   32'(bus.inst_req), 32'd0);
        check("ar_addr",  bus.inst_addr, 32'd0);
        check("ar_valid", 32'(fe_valid), 32'd0);
        check("ar_pc",    fe_pc, 32'd0);
        check("ar_inst",  fe_inst, 32'd0);
        step(); step();
        resetn = 1'b1;
        step();
        check("ar_restart", bus.inst_addr, 32'hBFC0_0000);
        check("ar_rreq",    32'(bus.inst_req), 32'd1);
        step(); step();
        check("ar_out", fe_pc, 32'hBFC0_0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
